// File: rtl/rock_hit_detector_if.sv
// Bundle of the scan-side inputs and the game-state outputs of the rock hit
// detector. The video/rock pipeline drives the master side; the detector is
// the slave.
interface rock_hit_detector_if #(
    parameter int NUM_ROCKS = 10,
    parameter int SCORE_W   = 16
);
    logic [9:0]           px;
    logic [9:0]           py;
    logic [NUM_ROCKS-1:0] rock_pixel;
    logic                 ship_pixel;
    logic                 bullet_pixel;
    logic                 frame_end;
    logic                 start;
    logic [NUM_ROCKS-1:0] rock_reset;
    logic                 bullet_kill;
    logic                 ship_hit;
    logic [SCORE_W-1:0]   score;
    logic [2:0]           lives;
    logic                 game_over;

    modport master (
        output px, py, rock_pixel, ship_pixel, bullet_pixel, frame_end, start,
        input  rock_reset, bullet_kill, ship_hit, score, lives, game_over
    );

    modport slave (
        input  px, py, rock_pixel, ship_pixel, bullet_pixel, frame_end, start,
        output rock_reset, bullet_kill, ship_hit, score, lives, game_over
    );
endinterface

// File: rtl/rock_hit_detector.sv
// Rock hit detector: accumulates rock/bullet and rock/ship overlaps over the
// visible part of a frame, reports them in a single cycle after frame_end
// (destroy pulses back to the rock manager), and keeps score, lives and the
// game-over state. All outputs come straight from registers.
module rock_hit_detector #(
    parameter int NUM_ROCKS  = 10,
    parameter int SCORE_W    = 16,
    parameter int LIVES_INIT = 3,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480
) (
    input  logic               clk,
    input  logic               resetn,
    rock_hit_detector_if.slave bus
);

    typedef enum logic [1:0] {
        ST_SCAN      = 2'd0,
        ST_REPORT    = 2'd1,
        ST_GAME_OVER = 2'd2
    } state_t;

    localparam logic [SCORE_W-1:0]   SCORE_MAX  = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0]   SCORE_ZERO = {SCORE_W{1'b0}};
    localparam logic [2:0]           LIVES_LOAD = 3'(LIVES_INIT);
    localparam logic [NUM_ROCKS-1:0] ROCKS_ALL  = {NUM_ROCKS{1'b1}};
    localparam logic [NUM_ROCKS-1:0] ROCKS_NONE = {NUM_ROCKS{1'b0}};
    // One extra bit so the comparison also holds for limits up to 1024.
    localparam logic [10:0]          H_LIMIT    = 11'(H_ACTIVE);
    localparam logic [10:0]          V_LIMIT    = 11'(V_ACTIVE);

    // Number of set bits in a rock vector, widened to the score adder width.
    function automatic logic [SCORE_W:0] popcount(input logic [NUM_ROCKS-1:0] v);
        logic [SCORE_W:0] cnt;
        cnt = {(SCORE_W+1){1'b0}};
        for (int i = 0; i < NUM_ROCKS; i++) begin
            cnt = cnt + {{SCORE_W{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    // Score addition that sticks at the maximum instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W:0]   b);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + b;
        if (sum > {1'b0, SCORE_MAX}) begin
            return SCORE_MAX;
        end else begin
            return sum[SCORE_W-1:0];
        end
    endfunction

    // Lives decrement floored at zero.
    function automatic logic [2:0] lives_dec(input logic [2:0] l);
        if (l == 3'd0) begin
            return 3'd0;
        end else begin
            return l - 3'd1;
        end
    endfunction

    state_t               state_r,  state_next_s;
    logic [NUM_ROCKS-1:0] bhit_r,   bhit_next_s;
    logic [NUM_ROCKS-1:0] shit_r,   shit_next_s;
    logic [SCORE_W-1:0]   score_r,  score_next_s;
    logic [2:0]           lives_r,  lives_next_s;
    logic [NUM_ROCKS-1:0] rock_reset_r, rock_reset_next_s;
    logic                 bullet_kill_r, bullet_kill_next_s;
    logic                 ship_hit_r, ship_hit_next_s;
    logic                 game_over_r, game_over_next_s;

    logic                 sample_en_s;
    logic [NUM_ROCKS-1:0] bhit_sample_s;
    logic [NUM_ROCKS-1:0] shit_sample_s;

    // Overlaps seen at the current pixel, masked to the visible area.
    always_comb begin
        sample_en_s   = ({1'b0, bus.px} < H_LIMIT) && ({1'b0, bus.py} < V_LIMIT);
        bhit_sample_s = bus.rock_pixel & {NUM_ROCKS{bus.bullet_pixel & sample_en_s}};
        shit_sample_s = bus.rock_pixel & {NUM_ROCKS{bus.ship_pixel & sample_en_s}};
    end

    // Next-state, accumulator, counter and output decode. Outputs are
    // computed for the state being entered so they can be registered and
    // still line up with that state's cycle.
    always_comb begin
        state_next_s       = state_r;
        bhit_next_s        = bhit_r;
        shit_next_s        = shit_r;
        score_next_s       = score_r;
        lives_next_s       = lives_r;
        rock_reset_next_s  = ROCKS_NONE;
        bullet_kill_next_s = 1'b0;
        ship_hit_next_s    = 1'b0;
        game_over_next_s   = 1'b0;

        case (state_r)
            ST_SCAN: begin
                // Samples of the frame_end cycle are part of this report.
                bhit_next_s = bhit_r | bhit_sample_s;
                shit_next_s = shit_r | shit_sample_s;
                if (bus.frame_end) begin
                    state_next_s       = ST_REPORT;
                    rock_reset_next_s  = bhit_next_s | shit_next_s;
                    bullet_kill_next_s = |bhit_next_s;
                    ship_hit_next_s    = |shit_next_s;
                end else begin
                    state_next_s = ST_SCAN;
                end
            end

            ST_REPORT: begin
                // A rock hit by both bullet and ship is one bit in each
                // vector: it scores once and the ship vector costs one life.
                score_next_s = sat_add(score_r, popcount(bhit_r));
                if (|shit_r) begin
                    lives_next_s = lives_dec(lives_r);
                end else begin
                    lives_next_s = lives_r;
                end
                bhit_next_s = ROCKS_NONE;
                shit_next_s = ROCKS_NONE;
                if (lives_next_s == 3'd0) begin
                    state_next_s      = ST_GAME_OVER;
                    rock_reset_next_s = ROCKS_ALL;
                    game_over_next_s  = 1'b1;
                end else begin
                    state_next_s = ST_SCAN;
                end
            end

            ST_GAME_OVER: begin
                if (bus.start) begin
                    state_next_s = ST_SCAN;
                    score_next_s = SCORE_ZERO;
                    lives_next_s = LIVES_LOAD;
                    bhit_next_s  = ROCKS_NONE;
                    shit_next_s  = ROCKS_NONE;
                end else begin
                    // Keep every rock held in reset while the game is over.
                    state_next_s      = ST_GAME_OVER;
                    rock_reset_next_s = ROCKS_ALL;
                    game_over_next_s  = 1'b1;
                end
            end

            default: begin
                state_next_s = ST_SCAN;
                bhit_next_s  = ROCKS_NONE;
                shit_next_s  = ROCKS_NONE;
            end
        endcase
    end

    // State, accumulators, counters and registered outputs; reset drops any
    // pending hits so no destroy pulse leaks out of an interrupted frame.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r       <= ST_SCAN;
            bhit_r        <= ROCKS_NONE;
            shit_r        <= ROCKS_NONE;
            score_r       <= SCORE_ZERO;
            lives_r       <= LIVES_LOAD;
            rock_reset_r  <= ROCKS_NONE;
            bullet_kill_r <= 1'b0;
            ship_hit_r    <= 1'b0;
            game_over_r   <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            bhit_r        <= bhit_next_s;
            shit_r        <= shit_next_s;
            score_r       <= score_next_s;
            lives_r       <= lives_next_s;
            rock_reset_r  <= rock_reset_next_s;
            bullet_kill_r <= bullet_kill_next_s;
            ship_hit_r    <= ship_hit_next_s;
            game_over_r   <= game_over_next_s;
        end
    end

    assign bus.rock_reset  = rock_reset_r;
    assign bus.bullet_kill = bullet_kill_r;
    assign bus.ship_hit    = ship_hit_r;
    assign bus.score       = score_r;
    assign bus.lives       = lives_r;
    assign bus.game_over   = game_over_r;

endmodule

// File: tb/tb_rock_hit_detector.sv
// Self-checking bench for rock_hit_detector: directed scenarios plus random
// frames, compared against a frame-level reference model kept here.
module tb_rock_hit_detector;

    localparam int NR = 10;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    rock_hit_detector_if #(.NUM_ROCKS(NR), .SCORE_W(16)) bus ();

    rock_hit_detector #(
        .NUM_ROCKS (NR),
        .SCORE_W   (16),
        .LIVES_INIT(3),
        .H_ACTIVE  (640),
        .V_ACTIVE  (480)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: which rocks were touched this frame, and game counters.
    logic [NR-1:0] m_b;
    logic [NR-1:0] m_s;
    int            m_score;
    int            m_lives;
    bit            m_over;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int count_ones(input logic [NR-1:0] v);
        int n = 0;
        for (int i = 0; i < NR; i++) if (v[i]) n++;
        return n;
    endfunction

    task automatic model_reset();
        m_b = '0; m_s = '0; m_score = 0; m_lives = 3; m_over = 1'b0;
    endtask

    task automatic drive(input logic [9:0] x, input logic [9:0] y, input logic [NR-1:0] rk,
                         input logic s, input logic b, input logic fe, input logic st);
        bus.px = x; bus.py = y; bus.rock_pixel = rk; bus.ship_pixel = s;
        bus.bullet_pixel = b; bus.frame_end = fe; bus.start = st;
    endtask

    task automatic model_sample(input logic [9:0] x, input logic [9:0] y, input logic [NR-1:0] rk,
                                input logic s, input logic b);
        if (!m_over && x < 10'd640 && y < 10'd480) begin
            for (int i = 0; i < NR; i++) begin
                if (rk[i] && b) m_b[i] = 1'b1;
                if (rk[i] && s) m_s[i] = 1'b1;
            end
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".rock_reset"}, 32'(bus.rock_reset), m_over ? 32'h3FF : 32'h0);
        chk({tag, ".bullet_kill"}, 32'(bus.bullet_kill), 32'h0);
        chk({tag, ".ship_hit"}, 32'(bus.ship_hit), 32'h0);
        chk({tag, ".game_over"}, 32'(bus.game_over), 32'(m_over));
        chk({tag, ".score"}, 32'(bus.score), 32'(m_score));
        chk({tag, ".lives"}, 32'(bus.lives), 32'(m_lives));
    endtask

    task automatic hit_cycle(input logic [9:0] x, input logic [9:0] y, input logic [NR-1:0] rk,
                             input logic s, input logic b, input logic st);
        drive(x, y, rk, s, b, 1'b0, st);
        model_sample(x, y, rk, s, b);
        @(posedge clk); #1;
        check_idle("scan");
    endtask

    // frame_end cycle (with its own pixel inputs), the report cycle and the
    // first cycle after it.
    task automatic end_frame(input logic [9:0] x, input logic [9:0] y, input logic [NR-1:0] rk,
                             input logic s, input logic b);
        int sum;
        drive(x, y, rk, s, b, 1'b1, 1'b0);
        model_sample(x, y, rk, s, b);
        @(posedge clk); #1;
        drive(10'd0, 10'd500, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (m_over) begin
            check_idle("fe_in_over");
            @(posedge clk); #1;
            check_idle("fe_in_over2");
        end else begin
            chk("report.rock_reset", 32'(bus.rock_reset), 32'(m_b | m_s));
            chk("report.bullet_kill", 32'(bus.bullet_kill), 32'(m_b != '0));
            chk("report.ship_hit", 32'(bus.ship_hit), 32'(m_s != '0));
            chk("report.game_over", 32'(bus.game_over), 32'h0);
            chk("report.score_old", 32'(bus.score), 32'(m_score));
            sum = m_score + count_ones(m_b);
            m_score = (sum > 65535) ? 65535 : sum;
            if (m_s != '0 && m_lives > 0) m_lives = m_lives - 1;
            m_over = (m_lives == 0);
            m_b = '0; m_s = '0;
            @(posedge clk); #1;
            check_idle("post_report");
        end
    endtask

    task automatic restart();
        drive(10'd0, 10'd500, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        if (m_over) begin
            m_over = 1'b0; m_score = 0; m_lives = 3; m_b = '0; m_s = '0;
        end
        @(posedge clk); #1;
        drive(10'd0, 10'd500, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_idle("restart");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] mask;
        int            rem;

        // Reset state
        resetn = 1'b0;
        drive(10'd0, 10'd500, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        @(negedge clk);
        resetn = 1'b1;

        // Single bullet hit on rock 3
        hit_cycle(10'd100, 10'd50, 10'h008, 1'b0, 1'b1, 1'b0);
        end_frame(10'd0, 10'd500, '0, 1'b0, 1'b0);
        chk("bullet.score", 32'(bus.score), 32'd1);
        chk("bullet.lives", 32'(bus.lives), 32'd3);

        // Overlaps in horizontal and vertical blanking are ignored
        hit_cycle(10'd700, 10'd50, 10'h001, 1'b0, 1'b1, 1'b0);
        hit_cycle(10'd100, 10'd480, 10'h001, 1'b1, 1'b1, 1'b0);
        end_frame(10'd640, 10'd10, 10'h002, 1'b0, 1'b1);
        chk("blank.score", 32'(bus.score), 32'd1);

        // Preload the score close to the top; hits land on the frame_end cycle
        while (m_score + 10 <= 65534) begin
            end_frame(10'd10, 10'd10, 10'h3FF, 1'b0, 1'b1);
        end
        rem = 65534 - m_score;
        if (rem > 0) begin
            mask = NR'((32'd1 << rem) - 32'd1);
            end_frame(10'd10, 10'd10, mask, 1'b0, 1'b1);
        end
        chk("sat.preload", 32'(bus.score), 32'hFFFE);
        hit_cycle(10'd20, 10'd20, 10'h001, 1'b0, 1'b1, 1'b0);
        hit_cycle(10'd30, 10'd20, 10'h002, 1'b0, 1'b1, 1'b0);
        end_frame(10'd40, 10'd20, 10'h004, 1'b0, 1'b1);
        chk("sat.score", 32'(bus.score), 32'hFFFF);
        end_frame(10'd10, 10'd10, 10'h3FF, 1'b0, 1'b1);
        chk("sat.nowrap", 32'(bus.score), 32'hFFFF);

        // Ship collides with rock 5 in three frames -> game over
        for (int f = 0; f < 3; f++) begin
            hit_cycle(10'd200, 10'd200, 10'h020, 1'b1, 1'b0, 1'b0);
            end_frame(10'd0, 10'd500, '0, 1'b0, 1'b0);
        end
        chk("ship.game_over", 32'(bus.game_over), 32'd1);
        chk("ship.lives", 32'(bus.lives), 32'd0);
        hit_cycle(10'd200, 10'd200, 10'h3FF, 1'b1, 1'b1, 1'b0);
        hit_cycle(10'd300, 10'd100, 10'h0F0, 1'b1, 1'b1, 1'b0);
        end_frame(10'd10, 10'd10, 10'h3FF, 1'b1, 1'b1);

        // Restart from game over, then a clean frame
        restart();
        chk("restart.lives", 32'(bus.lives), 32'd3);
        chk("restart.score", 32'(bus.score), 32'd0);
        end_frame(10'd0, 10'd500, '0, 1'b0, 1'b0);

        // Random frames (start pulses in SCAN must be ignored)
        for (int f = 0; f < 60; f++) begin
            if (m_over) restart();
            for (int c = 0; c < int'($urandom_range(3, 15)); c++) begin
                hit_cycle(10'($urandom_range(0, 799)), 10'($urandom_range(0, 524)),
                          NR'($urandom & $urandom & $urandom),
                          ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 9) == 0));
            end
            end_frame(10'($urandom_range(0, 799)), 10'($urandom_range(0, 524)),
                      NR'($urandom & $urandom), ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 2) == 0));
        end

        // Overlap on the frame_end cycle, then reset during REPORT
        if (m_over) restart();
        hit_cycle(10'd50, 10'd60, 10'h100, 1'b0, 1'b1, 1'b0);
        drive(10'd300, 10'd300, 10'h001, 1'b0, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(10'd0, 10'd500, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("edge.rock_reset", 32'(bus.rock_reset), 32'h101);
        chk("edge.bullet_kill", 32'(bus.bullet_kill), 32'h1);
        #1;
        resetn = 1'b0;
        #1;
        model_reset();
        chk("rst_report.rock_reset", 32'(bus.rock_reset), 32'h0);
        chk("rst_report.bullet_kill", 32'(bus.bullet_kill), 32'h0);
        chk("rst_report.score", 32'(bus.score), 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        end_frame(10'd0, 10'd500, '0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
